// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Optional leading-zero blanking mask is built when BCD_LZ_BLANK_EN is defined.
module bcd_seq_converter #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state;
  logic [IN_W-1:0]     r_shift;
  logic [4*DIGITS-1:0] r_dig;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_out_valid;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_dig_nxt;
  logic                w_last;
  logic                w_accept;

  // Add-3 correction is applied before the shift, so the MS bit of the
  // corrected top digit is exactly the carry lost off the top of the register.
  always_comb begin
    w_adj = r_dig;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_dig[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_dig[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_dig_nxt = {w_adj[4*DIGITS-2:0], r_shift[IN_W-1]};
  assign w_last    = (r_cnt == CW'(IN_W - 1));
  assign w_accept  = (r_state == S_IDLE) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_dig       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= in_data;
            r_dig   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_dig   <= w_dig_nxt;
          r_shift <= {r_shift[IN_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CW'(1);
          if (w_adj[4*DIGITS-1]) begin
            r_ovf <= 1'b1;
          end
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign bcd       = r_dig;
  assign ovf       = r_ovf;

`ifdef BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_nxt;
  logic              w_zero_run;

  // Scan from the MS digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    w_blank_nxt = '0;
    w_zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero_run     = w_zero_run & (w_dig_nxt[4*k +: 4] == 4'd0);
      w_blank_nxt[k] = w_zero_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blank <= '0;
    end else if (w_accept) begin
      r_blank <= '0;
    end else if (r_state == S_SHIFT && w_last) begin
      r_blank <= w_blank_nxt;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

endmodule
